// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back register-file stage.
package wb_pkg;

  localparam logic SEL_MEM  = 1'b1;
  localparam logic SEL_ALU  = 1'b0;
  localparam logic SRC_BYTE = 1'b1;
  localparam logic SRC_WORD = 1'b0;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 4;
  localparam int LANES_DEF = 4;
  localparam int CW_DEF    = 16;

  localparam int LPW = $clog2(LANES_DEF);
  typedef logic [LPW-1:0] lane_ptr_t;

endpackage

// File: rtl/vec_lane_packer.sv
// Per-vector-register byte-lane pointers and the lane-insert merge for streamed pixels.
module vec_lane_packer
  import wb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_word_i,
  input  logic          we_byte_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] old_word_i,
  input  logic [7:0]    byte_i,
  output logic [DW-1:0] merged_o,
  output lane_ptr_t     ptr_nxt_o,
  output logic          full_o
);

  localparam int        NREG = 1 << AW;
  localparam lane_ptr_t LAST = lane_ptr_t'(LANES - 1);

  lane_ptr_t ptr_q [NREG];
  lane_ptr_t ptr_cur;

  assign ptr_cur = ptr_q[addr_i];

  // NOTE: every output gets a default before the conditional updates, so no latch is inferred.
  always_comb begin
    merged_o                     = old_word_i;
    merged_o[{ptr_cur, 3'b000} +: 8] = byte_i;
    ptr_nxt_o                    = (ptr_cur == LAST) ? '0 : ptr_cur + 1'b1;
    full_o                       = we_byte_i && (ptr_cur == LAST);
  end

  // NOTE: the pointer array is reset because a reset must discard any partially packed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) ptr_q[i] <= '0;
    end else if (we_word_i) begin
      ptr_q[addr_i] <= '0;
    end else if (we_byte_i) begin
      ptr_q[addr_i] <= ptr_nxt_o;
    end
  end

endmodule

// File: rtl/wb_regfile_writer.sv
// Write-back stage: owns scalar and vector register files, bypassed read ports and retire status.
module wb_regfile_writer
  import wb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int LANES = LANES_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SEL_DAT,
  input  logic          SEL_C,
  input  logic          WE_C,
  input  logic          WE_V,
  input  logic          PROHIB_WB,
  input  logic [DW-1:0] Do,
  input  logic [7:0]    Dob,
  input  logic [DW-1:0] ALU_Result,
  input  logic [AW-1:0] Rg,
  input  logic [AW-1:0] RA_A,
  input  logic [AW-1:0] RA_B,
  input  logic [AW-1:0] RV_A,
  output logic [DW-1:0] RD_A,
  output logic [DW-1:0] RD_B,
  output logic [DW-1:0] RV_D,
  output logic [DW-1:0] WB_DATA,
  output logic          WB_VALID,
  output logic          VEC_FULL,
  output logic [CW-1:0] RETIRED
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] s_q [NREG];
  logic [DW-1:0] v_q [NREG];

  logic          wr_valid, s_we, vw_we, vb_we, v_we, full;
  logic [DW-1:0] wsel, v_merged, v_new;
  lane_ptr_t     ptr_nxt;

  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [CW-1:0] retired_q, retired_d;
  logic          wb_valid_q, vec_full_q;

  assign wsel = (SEL_DAT == SEL_MEM)
              ? ((SEL_C == SRC_BYTE) ? {{(DW-8){1'b0}}, Dob} : Do)
              : ALU_Result;

  assign wr_valid = (WE_C | WE_V) & ~PROHIB_WB;
  assign s_we     = WE_C & ~PROHIB_WB & (Rg != '0);
  assign vw_we    = WE_V & (SEL_C == SRC_WORD) & ~PROHIB_WB;
  assign vb_we    = WE_V & (SEL_C == SRC_BYTE) & ~PROHIB_WB;
  assign v_we     = vw_we | vb_we;
  assign v_new    = vb_we ? v_merged : wsel;

  vec_lane_packer #(.DW(DW), .AW(AW), .LANES(LANES)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_word_i  (vw_we),
    .we_byte_i  (vb_we),
    .addr_i     (Rg),
    .old_word_i (v_q[Rg]),
    .byte_i     (Dob),
    .merged_o   (v_merged),
    .ptr_nxt_o  (ptr_nxt),
    .full_o     (full)
  );

  // Reads return the value the array will hold after this edge when the address is being written.
  always_comb begin
    RD_A = '0;
    RD_B = '0;
    if (RA_A != '0) RD_A = (s_we && RA_A == Rg) ? wsel : s_q[RA_A];
    if (RA_B != '0) RD_B = (s_we && RA_B == Rg) ? wsel : s_q[RA_B];
    RV_D = (v_we && RV_A == Rg) ? v_new : v_q[RV_A];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) s_q[i] <= '0;
    end else if (s_we) begin
      s_q[Rg] <= wsel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) v_q[i] <= '0;
    end else if (v_we) begin
      v_q[Rg] <= v_new;
    end
  end

  assign wb_data_d = wr_valid ? wsel : wb_data_q;
  assign retired_d = wr_valid ? retired_q + 1'b1 : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q  <= '0;
      retired_q  <= '0;
      wb_valid_q <= 1'b0;
      vec_full_q <= 1'b0;
    end else begin
      wb_data_q  <= wb_data_d;
      retired_q  <= retired_d;
      wb_valid_q <= wr_valid;
      vec_full_q <= full;
    end
  end

  assign WB_DATA  = wb_data_q;
  assign WB_VALID = wb_valid_q;
  assign VEC_FULL = vec_full_q;
  assign RETIRED  = retired_q;

endmodule
